// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares a single-port data memory between the CPU MEM stage (port C) and a
//   loader/DMA engine (port D). One access is granted per clock. Contention is
//   resolved round-robin, and port D may hold the memory for a bounded burst
//   of up to MAX_BURST consecutive grants while it keeps d_lock asserted.
//   Read data from data_mem arrives one cycle after the address and is
//   steered back to whichever port issued the read.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata       CPU request, write flag, address, data
//   c_gnt, c_rvalid, c_rdata        CPU grant, read-data valid, read data
//   cpu_stall                       c_req & ~c_gnt, back to the pipeline
//   d_req/d_we/d_lock/d_addr/d_wdata  DMA request, write, burst lock, addr, data
//   d_gnt, d_rvalid, d_rdata        DMA grant, read-data valid, read data
//   mem_w_en/mem_addr/mem_w_data    data_mem write enable, address, write data
//   mem_r_data                      data_mem read data (1-cycle latency)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              cpu_stall,
  // DMA port
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // Memory side
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Registered state
  logic [0:0]        r_fsm;
  logic              r_last;      // 1 = port D was served last
  logic [CNT_W-1:0]  r_burst_cnt;
  logic              r_rd_pend;
  logic              r_rd_owner;  // 1 = pending read belongs to port D
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  // Combinational decisions
  logic w_burst_cont;
  logic w_c_wins_tie;
  logic w_c_gnt;
  logic w_d_gnt;
  logic w_c_rvalid;
  logic w_d_rvalid;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_burst_cont = 1'b0;
    w_c_wins_tie = r_last;
    w_c_gnt      = 1'b0;
    w_d_gnt      = 1'b0;

    // A burst continues only while D keeps requesting with lock and has grants left.
    w_burst_cont = (r_fsm == ST_BURST) && d_req && d_lock && (r_burst_cnt < CNT_MAX);

    // When a burst ends, the CPU gets the next tie regardless of history.
    if (r_fsm == ST_BURST) begin
      w_c_wins_tie = 1'b1;
    end

    if (!rst_n) begin
      // Grants are suppressed while reset is held, even with requests pending.
      w_c_gnt = 1'b0;
      w_d_gnt = 1'b0;
    end else if (w_burst_cont) begin
      w_d_gnt = 1'b1;
    end else if (c_req && d_req) begin
      w_c_gnt = w_c_wins_tie;
      w_d_gnt = !w_c_wins_tie;
    end else begin
      w_c_gnt = c_req;
      w_d_gnt = d_req;
    end
  end

  assign c_gnt     = w_c_gnt;
  assign d_gnt     = w_d_gnt;
  assign cpu_stall = c_req && !w_c_gnt;

  // ---------------------------------------------------------------------------
  // Memory-side mux: driven from the winner, all zero when nobody is granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_w_en   = 1'b0;
    mem_addr   = '0;
    mem_w_data = '0;
    if (w_c_gnt) begin
      mem_w_en   = c_we;
      mem_addr   = c_addr;
      mem_w_data = c_wdata;
    end else if (w_d_gnt) begin
      mem_w_en   = d_we;
      mem_addr   = d_addr;
      mem_w_data = d_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: memory data flows straight through in the cycle after the
  // read grant; the port that is not receiving data shows its last value.
  // ---------------------------------------------------------------------------
  assign w_c_rvalid = r_rd_pend && !r_rd_owner;
  assign w_d_rvalid = r_rd_pend &&  r_rd_owner;

  assign c_rvalid = w_c_rvalid;
  assign d_rvalid = w_d_rvalid;
  assign c_rdata  = w_c_rvalid ? mem_r_data : r_c_rdata;
  assign d_rdata  = w_d_rvalid ? mem_r_data : r_d_rdata;

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and ordering between blocks cannot change results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= ST_ARB;
      r_last      <= 1'b1;
      r_burst_cnt <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_owner  <= 1'b0;
      r_c_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      if (w_c_gnt || w_d_gnt) begin
        r_last <= w_d_gnt;
      end

      case (r_fsm)
        ST_ARB: begin
          if (w_d_gnt && d_lock) begin
            r_fsm       <= ST_BURST;
            r_burst_cnt <= CNT_ONE;
          end
        end
        default: begin
          if (w_burst_cont) begin
            r_burst_cnt <= r_burst_cnt + CNT_ONE;
          end else begin
            // The fallback grant this cycle does not start a new burst.
            r_fsm       <= ST_ARB;
            r_burst_cnt <= '0;
          end
        end
      endcase

      r_rd_pend <= (w_c_gnt && !c_we) || (w_d_gnt && !d_we);
      if (w_c_gnt || w_d_gnt) begin
        r_rd_owner <= w_d_gnt;
      end

      // Capture delivered data so each port's rdata holds between reads.
      if (w_c_rvalid) begin
        r_c_rdata <= mem_r_data;
      end
      if (w_d_rvalid) begin
        r_d_rdata <= mem_r_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed scenarios followed by a randomized run for dmem_arbiter. The bench
//   plays the part of data_mem (one-cycle read latency) and keeps its own
//   reference model: a served-last flag, the length of the current locked D
//   run, a shadow copy of memory and the read awaiting return.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;

  logic              clk;
  logic              rst_n;
  logic              c_req, c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt, c_rvalid, cpu_stall;
  logic [DATA_W-1:0] c_rdata;
  logic              d_req, d_we, d_lock;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;

  dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .cpu_stall (cpu_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_lock    (d_lock),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial memory image, a pure function of the address.
  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 ^ {a, 8'h00, ~a, a};
  endfunction

  // data_mem stand-in: 256 words indexed by the low address byte.
  logic [31:0] mem_q   [256];
  logic        mem_vld [256];
  always @(posedge clk) begin
    if (mem_w_en) begin
      mem_q[mem_addr[7:0]]   <= mem_w_data;
      mem_vld[mem_addr[7:0]] <= 1'b1;
    end
    mem_r_data <= (mem_vld[mem_addr[7:0]] === 1'b1) ? mem_q[mem_addr[7:0]]
                                                    : init_word(mem_addr[7:0]);
  end

  // Counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [256];
  bit          m_last;      // D was served most recently
  int          m_run;       // grants so far in the current locked D run (0 = none)
  bit          m_pend;
  bit          m_pown;      // 1 = pending read returns to D
  logic [31:0] m_pdata;
  logic [31:0] m_c_hold, m_d_hold;
  bit          m_gc, m_gd;  // model grants of the most recent step

  task automatic model_reset();
    m_last   = 1'b1;
    m_run    = 0;
    m_pend   = 1'b0;
    m_pown   = 1'b0;
    m_c_hold = '0;
    m_d_hold = '0;
    m_gc     = 1'b0;
    m_gd     = 1'b0;
  endtask

  // Compare DUT against the model for the current cycle, then advance the model.
  task automatic model_and_check();
    bit          exp_cv, exp_dv, gc, gd, in_run, cont, c_first;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wd;

    exp_cv = m_pend && !m_pown;
    exp_dv = m_pend &&  m_pown;
    if (exp_cv) m_c_hold = m_pdata;
    if (exp_dv) m_d_hold = m_pdata;
    check("c_rvalid", c_rvalid, exp_cv);
    check("d_rvalid", d_rvalid, exp_dv);
    check("c_rdata",  c_rdata,  m_c_hold);
    check("d_rdata",  d_rdata,  m_d_hold);

    in_run = (m_run > 0);
    cont   = in_run && (m_run < MAX_BURST) && d_req && d_lock;
    gc = 1'b0;
    gd = 1'b0;
    if (cont) begin
      gd = 1'b1;
    end else begin
      c_first = in_run || m_last;
      if (c_req && d_req) begin
        gc = c_first;
        gd = !c_first;
      end else begin
        gc = c_req;
        gd = d_req;
      end
    end

    exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    if (gc) begin
      exp_we = c_we; exp_addr = c_addr; exp_wd = c_wdata;
    end else if (gd) begin
      exp_we = d_we; exp_addr = d_addr; exp_wd = d_wdata;
    end
    check("c_gnt",      c_gnt,      gc);
    check("d_gnt",      d_gnt,      gd);
    check("cpu_stall",  cpu_stall,  c_req && !gc);
    check("mem_w_en",   mem_w_en,   exp_we);
    check("mem_addr",   mem_addr,   exp_addr);
    check("mem_w_data", mem_w_data, exp_wd);

    m_gc = gc;
    m_gd = gd;
    if (gc || gd) m_last = gd;
    if (in_run) m_run = cont ? m_run + 1 : 0;
    else        m_run = (gd && d_lock) ? 1 : 0;

    m_pend = (gc && !c_we) || (gd && !d_we);
    m_pown = gd;
    if (gc && !c_we) m_pdata = ref_mem[c_addr[7:0]];
    if (gd && !d_we) m_pdata = ref_mem[d_addr[7:0]];
    if (gc && c_we)  ref_mem[c_addr[7:0]] = c_wdata;
    if (gd && d_we)  ref_mem[d_addr[7:0]] = d_wdata;
  endtask

  // One clock of stimulus: drive on the falling edge, check 1 ns later.
  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic dl,
                      input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
    #1;
    model_and_check();
  endtask

  // Assert reset with both ports requesting, check quiet outputs, release.
  task automatic do_reset();
    rst_n = 1'b0;
    c_req = 1'b1;
    d_req = 1'b1;
    #1;
    check("rst c_gnt",    c_gnt,    1'b0);
    check("rst d_gnt",    d_gnt,    1'b0);
    check("rst c_rvalid", c_rvalid, 1'b0);
    check("rst d_rvalid", d_rvalid, 1'b0);
    check("rst mem_w_en", mem_w_en, 1'b0);
    check("rst c_rdata",  c_rdata,  32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    c_req = 1'b0;
    d_req = 1'b0;
    rst_n = 1'b1;
  endtask

  logic [5:0] stall_seq;
  logic [9:0] dgnt_seq;
  int         stall_cnt;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;
    #2;

    // 1: reset with both requesting
    do_reset();

    // 2: CPU-only read of 0x10
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    check("t2 c_gnt", c_gnt, 1'b1);
    check("t2 stall", cpu_stall, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t2 c_rvalid", c_rvalid, 1'b1);
    check("t2 c_rdata",  c_rdata,  32'hDEAD_BEEF);

    // 3: both request reads every cycle, no lock -> alternate starting with C
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 32'(i * 4), 0, 1, 0, 0, 32'(8'h80 + i * 4), 0);
      stall_seq[i] = cpu_stall;
    end
    check("t3 stall pattern", stall_seq, 6'b101010);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 4: locked burst -> C, then MAX_BURST D grants, then C
    do_reset();
    stall_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 32'h40, 0, 1, 0, 1, 32'(8'hA0 + i), 0);
      dgnt_seq[i] = d_gnt;
      if (cpu_stall) stall_cnt++;
    end
    check("t4 d_gnt pattern", dgnt_seq, 10'b0111111110);
    check("t4 stall count",   stall_cnt, 8);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 5: CPU write, visible on the memory side in the grant cycle
    step(1, 1, 32'h20, 32'h5A5A, 0, 0, 0, 0, 0);
    check("t5 mem_w_en",   mem_w_en,   1'b1);
    check("t5 mem_addr",   mem_addr,   32'h20);
    check("t5 mem_w_data", mem_w_data, 32'h5A5A);
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    check("t5 no rvalid", c_rvalid, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t5 readback", c_rdata, 32'h5A5A);

    // 6: reset during a burst with a D read in flight
    do_reset();
    step(0, 0, 0, 0, 1, 0, 1, 32'h60, 0);
    step(1, 0, 32'h64, 0, 1, 0, 1, 32'h61, 0);
    step(1, 0, 32'h64, 0, 1, 0, 1, 32'h62, 0);
    @(posedge clk);
    #2;
    check("t6 pend before rst", d_rvalid, 1'b1);
    do_reset();
    step(1, 0, 32'h64, 0, 1, 0, 0, 32'h63, 0);
    check("t6 tie to C", c_gnt, 1'b1);
    check("t6 no stale rvalid", d_rvalid, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic; a stalled requester holds its request fields.
    for (int i = 0; i < 800; i++) begin
      logic        cr, cw, dr, dw, dl;
      logic [31:0] ca, cd, da, dd;
      if (c_req && !m_gc) begin
        cr = c_req; cw = c_we; ca = c_addr; cd = c_wdata;
      end else begin
        cr = ($urandom_range(0, 3) != 0);
        cw = 1'($urandom_range(0, 1));
        ca = 32'($urandom_range(0, 255));
        cd = $urandom;
      end
      if (d_req && !m_gd) begin
        dr = d_req; dw = d_we; da = d_addr; dd = d_wdata;
      end else begin
        dr = ($urandom_range(0, 3) != 0);
        dw = 1'($urandom_range(0, 1));
        da = 32'($urandom_range(0, 255));
        dd = $urandom;
      end
      dl = ($urandom_range(0, 2) != 0);
      step(cr, cw, ca, cd, dr, dw, dl, da, dd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
